// File: rtl/adder_result_accumulator_pkg.sv
// Shared definitions for the adder result accumulator and other ALU stages
// that consume {carry-out, sum} beats from the narrow adder.
package adder_result_accumulator_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_e;

  localparam int unsigned ADDER_IN_W   = 4;
  localparam int unsigned ADDER_BEAT_W = ADDER_IN_W + 1;

  // A beat carries the adder sum plus its carry-out bit.
  function automatic int unsigned beat_width(input int unsigned in_w);
    return in_w + 1;
  endfunction

endpackage

// File: rtl/adder_result_accumulator_acc_datapath.sv
// Combinational add of one zero-extended beat into the running total, with
// sticky overflow taken from the carry out of the ACC_W-bit result.
module acc_datapath
  import adder_result_accumulator_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] acc,
  input  logic             ovf,
  input  logic [IN_W-1:0]  sum,
  input  logic             cout,
  output logic [ACC_W-1:0] acc_next,
  output logic             ovf_next
);

  localparam int unsigned BEAT_W = beat_width(IN_W);

  logic [ACC_W:0] beat;
  logic [ACC_W:0] total;

  always_comb begin
    beat     = {{(ACC_W + 1 - BEAT_W){1'b0}}, cout, sum};
    total    = {1'b0, acc} + beat;
    acc_next = total[ACC_W-1:0];
    ovf_next = ovf | total[ACC_W];
  end

endmodule

// File: rtl/adder_result_accumulator.sv
// Accumulates adder result beats into frames closed by in_last or a beat
// count, and hands each frame total downstream over a valid/ready port.
module adder_result_accumulator
  import adder_result_accumulator_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int ACC_W = 12,
  parameter int BEATS = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_cout,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // valid never depends on ready; once out_valid rises, out_* hold until taken.
  // in_ready is low for the whole HOLD state, so no beat is accepted in the
  // cycle a result is consumed.

  acc_state_e       state;
  acc_state_e       state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf;
  logic             ovf_next;
  logic             accept;
  logic             close;

  acc_datapath #(
    .IN_W (IN_W),
    .ACC_W(ACC_W)
  ) u_acc_datapath (
    .acc     (acc),
    .ovf     (ovf),
    .sum     (in_sum),
    .cout    (in_cout),
    .acc_next(acc_next),
    .ovf_next(ovf_next)
  );

  always_comb begin
    accept  = in_valid && in_ready;
    cnt_inc = cnt + CNT_W'(1);
    close   = accept && (in_last || (cnt_inc == CNT_W'(BEATS)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ACCUM: if (close) state_next = ST_HOLD;
      ST_HOLD:  if (out_ready) state_next = ST_ACCUM;
      default:  state_next = ST_ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_ACCUM);
    out_valid = (state == ST_HOLD);
  end

  // A closing beat publishes the post-beat totals and restarts the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      if (close) begin
        out_acc   <= acc_next;
        out_count <= cnt_inc;
        out_ovf   <= ovf_next;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else begin
        acc <= acc_next;
        cnt <= cnt_inc;
        ovf <= ovf_next;
      end
    end
  end

endmodule
